// File: rtl/note_color_fader_pkg.sv
// piano_color_pkg: shared definitions for the key-light colour blocks.
//   fader_state_t : fader FSM state encoding
//   PALETTE       : 16-entry note code -> {R,G,B} mask table
//   code_mapped() : true when a note code has a non-black palette entry
package piano_color_pkg;

    localparam int NOTE_W = 4;

    typedef logic [2:0] color_mask_t;   // {R, G, B}

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        HOLD = 2'd2,
        FADE = 2'd3
    } fader_state_t;

    localparam color_mask_t PALETTE [16] = '{
        3'b000,     // 0  unmapped
        3'b100,     // 1  red
        3'b010,     // 2  green
        3'b001,     // 3  blue
        3'b101,     // 4  magenta
        3'b110,     // 5  yellow
        3'b011,     // 6  cyan
        3'b111,     // 7  white
        3'b100,     // 8  red
        3'b010,     // 9  green
        3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000
    };

    function automatic logic code_mapped(input logic [NOTE_W-1:0] code);
        return PALETTE[code] != 3'b000;
    endfunction

endpackage

// File: rtl/note_color_fader_if.sv
// Keyboard-to-light bus.
//   key_on, key_code : pressed-key level and note code (from the note encoder)
//   R, G, B          : per-channel intensity, COLOR_W bits each
//   busy             : light is not idle
// master = keyboard side, slave = light driver.
interface note_color_fader_if #(
    parameter int COLOR_W = 4
);
    logic               key_on;
    logic [3:0]         key_code;
    logic [COLOR_W-1:0] R;
    logic [COLOR_W-1:0] G;
    logic [COLOR_W-1:0] B;
    logic               busy;

    modport master (output key_on, key_code, input R, G, B, busy);
    modport slave  (input key_on, key_code, output R, G, B, busy);
endinterface

// File: rtl/note_color_fader_palette.sv
// note_palette: combinational note code -> colour mask lookup.
//   key_code : 4-bit note code
//   mask     : {R,G,B} channel enables
//   mapped   : code has a colour (unmapped codes read as "no key")
import piano_color_pkg::*;

module note_palette (
    input  logic [3:0] key_code,
    output logic [2:0] mask,
    output logic       mapped
);
    assign mask   = PALETTE[key_code];
    assign mapped = code_mapped(key_code);
endmodule

// File: rtl/note_color_fader.sv
// note_color_fader: holds a note's colour at full intensity while the key is
// down, keeps it for HOLD_CYCLES after release, then fades it linearly to
// black, one step every FADE_DIV cycles.
//   clk, rst_n : system clock, async active-low reset
//   bus        : slave side of note_color_fader_if (key in, RGB/busy out)
//
// state | meaning
// IDLE  | dark, waiting for a mapped key press
// ON    | key held, full intensity, colour follows key_code
// HOLD  | key released, full intensity frozen for HOLD_CYCLES
// FADE  | intensity steps down by one every FADE_DIV cycles
import piano_color_pkg::*;

module note_color_fader #(
    parameter int COLOR_W     = 4,
    parameter int HOLD_CYCLES = 0,
    parameter int FADE_DIV    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    note_color_fader_if.slave    bus
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    // Down-counters are loaded with N-1 so terminal count 0 marks the N-th cycle.
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [FADE_W-1:0]  FADE_LOAD = FADE_W'((FADE_DIV > 0) ? FADE_DIV - 1 : 0);
    localparam logic [COLOR_W-1:0] FULL      = '1;
    localparam logic [COLOR_W-1:0] ONE       = COLOR_W'(1);

    fader_state_t       state;
    logic [2:0]         mask;
    logic [COLOR_W-1:0] intensity;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [FADE_W-1:0]  fade_cnt;

    logic [2:0] pal_mask;
    logic       pal_mapped;
    logic       press;

    note_palette u_palette (
        .key_code (bus.key_code),
        .mask     (pal_mask),
        .mapped   (pal_mapped)
    );

    assign press = bus.key_on && pal_mapped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask      <= '0;
            intensity <= '0;
            hold_cnt  <= '0;
            fade_cnt  <= '0;
        end else if (press) begin
            // A press overrides any hold expiry or fade step on this edge.
            state     <= ON;
            mask      <= pal_mask;
            intensity <= FULL;
        end else begin
            case (state)
                IDLE: ;
                ON: begin
                    if (HOLD_CYCLES > 0) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        state    <= FADE;
                        fade_cnt <= FADE_LOAD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state    <= FADE;
                        fade_cnt <= FADE_LOAD;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                FADE: begin
                    if (fade_cnt == '0) begin
                        fade_cnt <= FADE_LOAD;
                        // Last step lands on zero together with the return to IDLE.
                        if (intensity <= ONE) begin
                            state     <= IDLE;
                            mask      <= '0;
                            intensity <= '0;
                        end else begin
                            intensity <= intensity - ONE;
                        end
                    end else begin
                        fade_cnt <= fade_cnt - FADE_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.R    = mask[2] ? intensity : '0;
    assign bus.G    = mask[1] ? intensity : '0;
    assign bus.B    = mask[0] ? intensity : '0;
    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_note_color_fader.sv
module tb_note_color_fader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    note_color_fader_if #(.COLOR_W(4)) if_a ();
    note_color_fader_if #(.COLOR_W(4)) if_b ();

    note_color_fader #(.COLOR_W(4), .HOLD_CYCLES(3), .FADE_DIV(2)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (if_a.slave));
    note_color_fader #(.COLOR_W(4), .HOLD_CYCLES(0), .FADE_DIV(1)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (if_b.slave));

    int n_pass = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    int       m_hold [2] = '{3, 0};
    int       m_div  [2] = '{2, 1};
    bit       m_active [2];
    bit       m_held   [2];
    int       m_age    [2];
    logic [2:0] m_mask [2];

    function automatic logic [2:0] ref_mask(input logic [3:0] code);
        case (code)
            4'd1, 4'd8: return 3'b100;
            4'd2, 4'd9: return 3'b010;
            4'd3:       return 3'b001;
            4'd4:       return 3'b101;
            4'd5:       return 3'b110;
            4'd6:       return 3'b011;
            4'd7:       return 3'b111;
            default:    return 3'b000;
        endcase
    endfunction

    // Intensity as a function of cycles since release.
    function automatic int model_level(input int i);
        int steps;
        if (!m_active[i]) return 0;
        if (m_held[i] || m_age[i] <= m_hold[i]) return 15;
        steps = (m_age[i] - m_hold[i]) / m_div[i];
        return (steps >= 15) ? 0 : 15 - steps;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_held[i] = 1'b0; m_age[i] = 0; m_mask[i] = 3'b000;
        end
    endfunction

    function automatic void model_step(input int i, input logic on, input logic [3:0] code);
        logic [2:0] pm;
        pm = ref_mask(code);
        if (on && pm != 3'b000) begin
            m_active[i] = 1'b1; m_held[i] = 1'b1; m_mask[i] = pm;
        end else if (m_active[i]) begin
            if (m_held[i]) begin
                m_held[i] = 1'b0; m_age[i] = 0;
            end else begin
                m_age[i] = m_age[i] + 1;
            end
            if (model_level(i) == 0) begin
                m_active[i] = 1'b0; m_mask[i] = 3'b000;
            end
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic compare_model();
        int lvl;
        lvl = model_level(0);
        check("model_a_R",    if_a.R,    m_mask[0][2] ? lvl : 0);
        check("model_a_G",    if_a.G,    m_mask[0][1] ? lvl : 0);
        check("model_a_B",    if_a.B,    m_mask[0][0] ? lvl : 0);
        check("model_a_busy", if_a.busy, m_active[0] ? 1 : 0);
        lvl = model_level(1);
        check("model_b_R",    if_b.R,    m_mask[1][2] ? lvl : 0);
        check("model_b_G",    if_b.G,    m_mask[1][1] ? lvl : 0);
        check("model_b_B",    if_b.B,    m_mask[1][0] ? lvl : 0);
        check("model_b_busy", if_b.busy, m_active[1] ? 1 : 0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_a_rgb"},  {if_a.R, if_a.G, if_a.B}, 0);
        check({name, "_a_busy"}, if_a.busy, 0);
        check({name, "_b_rgb"},  {if_b.R, if_b.G, if_b.B}, 0);
        check({name, "_b_busy"}, if_b.busy, 0);
    endtask

    // Drive inputs, clock one edge, step model, compare on falling edge.
    task automatic tick(input logic on, input logic [3:0] code);
        if_a.key_on = on; if_a.key_code = code;
        if_b.key_on = on; if_b.key_code = code;
        @(posedge clk);
        if (rst_n) begin
            model_step(0, on, code);
            model_step(1, on, code);
        end
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_zero("reset_low");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table (DUT A: H=3, F=2) ----------------
    typedef struct {
        logic       on;
        logic [3:0] code;
        int         r, g, b, busy;
    } vec_t;

    vec_t vecs [12];

    logic       r_on;
    logic [3:0] r_code;
    int         r_len;

    initial begin
        vecs[0]  = '{1'b1, 4'd5,  15, 15, 0,  1};   // press yellow
        vecs[1]  = '{1'b1, 4'd3,  0,  0,  15, 1};   // recolour to blue while held
        vecs[2]  = '{1'b0, 4'd0,  0,  0,  15, 1};   // release edge r
        vecs[3]  = '{1'b0, 4'd0,  0,  0,  15, 1};   // r+1
        vecs[4]  = '{1'b0, 4'd0,  0,  0,  15, 1};   // r+2
        vecs[5]  = '{1'b0, 4'd0,  0,  0,  15, 1};   // r+3
        vecs[6]  = '{1'b0, 4'd0,  0,  0,  15, 1};   // r+4
        vecs[7]  = '{1'b0, 4'd0,  0,  0,  14, 1};   // r+5 first step
        vecs[8]  = '{1'b1, 4'd12, 0,  0,  14, 1};   // unmapped code = no key
        vecs[9]  = '{1'b0, 4'd0,  0,  0,  13, 1};   // r+7
        vecs[10] = '{1'b1, 4'd9,  0,  15, 0,  1};   // retrigger green
        vecs[11] = '{1'b1, 4'd0,  0,  15, 0,  1};   // code 0 releases, held

        if_a.key_on = 1'b1; if_a.key_code = 4'd5;
        if_b.key_on = 1'b1; if_b.key_code = 4'd5;
        model_clear();
        repeat (2) @(negedge clk);
        check_zero("in_reset");
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            tick(vecs[i].on, vecs[i].code);
            check($sformatf("vec%0d_R", i),    if_a.R,    vecs[i].r);
            check($sformatf("vec%0d_G", i),    if_a.G,    vecs[i].g);
            check($sformatf("vec%0d_B", i),    if_a.B,    vecs[i].b);
            check($sformatf("vec%0d_busy", i), if_a.busy, vecs[i].busy);
        end

        // Full fade of blue on A.
        do_reset();
        tick(1'b1, 4'd3);
        tick(1'b0, 4'd0);
        for (int a = 1; a <= 33; a++) begin
            tick(1'b0, 4'd0);
            if (a == 3)  check("fade_b_r3",  if_a.B, 15);
            if (a == 5)  check("fade_b_r5",  if_a.B, 14);
            if (a == 32) check("fade_b_r32", {if_a.busy, if_a.B}, {1'b1, 4'd1});
            if (a == 33) check("fade_b_r33", {if_a.busy, if_a.B}, 0);
            check("fade_rg_zero", {if_a.R, if_a.G}, 0);
        end

        // Unmapped press from idle.
        repeat (3) tick(1'b1, 4'd12);
        check("unmapped_idle", {if_a.busy, if_a.R, if_a.G, if_a.B}, 0);

        // White then code change to unmapped acts as release.
        tick(1'b1, 4'd7);
        tick(1'b1, 4'd12);
        for (int a = 1; a <= 5; a++) tick(1'b1, 4'd12);
        check("white_to_12", {if_a.R, if_a.G, if_a.B}, {4'd14, 4'd14, 4'd14});

        // Retrigger during fade.
        do_reset();
        tick(1'b1, 4'd1);
        tick(1'b0, 4'd0);
        for (int a = 1; a <= 9; a++) tick(1'b0, 4'd0);
        check("pre_retrig_R", if_a.R, 12);
        tick(1'b1, 4'd6);
        check("retrig_rgb", {if_a.busy, if_a.R, if_a.G, if_a.B}, {1'b1, 4'd0, 4'd15, 4'd15});
        tick(1'b0, 4'd0);
        for (int a = 1; a <= 5; a++) begin
            tick(1'b0, 4'd0);
            if (a == 4) check("retrig_hold_again", if_a.G, 15);
            if (a == 5) check("retrig_fade_again", if_a.G, 14);
        end

        // DUT B: no hold, one-cycle steps.
        do_reset();
        tick(1'b1, 4'd4);
        tick(1'b0, 4'd0);
        check("b_release_full", if_b.R, 15);
        for (int a = 1; a <= 15; a++) begin
            tick(1'b0, 4'd0);
            if (a == 1)  check("b_r1", {if_b.R, if_b.G, if_b.B}, {4'd14, 4'd0, 4'd14});
            if (a == 15) check("b_r15", {if_b.busy, if_b.R, if_b.B}, 0);
        end
        tick(1'b1, 4'd4);
        tick(1'b0, 4'd0);
        for (int a = 1; a <= 14; a++) tick(1'b0, 4'd0);
        check("b_r14_level", if_b.R, 1);
        tick(1'b1, 4'd4);
        check("b_press_wins", {if_b.busy, if_b.R, if_b.B}, {1'b1, 4'd15, 4'd15});

        // Async reset mid-hold.
        do_reset();
        tick(1'b1, 4'd7);
        tick(1'b0, 4'd0);
        tick(1'b0, 4'd0);
        check("pre_async_white", if_a.R, 15);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_zero("async_mid_hold");
        @(posedge clk);
        @(negedge clk);
        check_zero("async_held");
        rst_n = 1'b1;
        tick(1'b0, 4'd0);
        check_zero("no_stale");
        tick(1'b1, 4'd2);
        check("post_reset_press", {if_a.busy, if_a.G}, {1'b1, 4'd15});

        // Randomized segments against the model.
        do_reset();
        for (int s = 0; s < 150; s++) begin
            r_on   = ($urandom_range(0, 2) == 0);
            r_code = 4'($urandom_range(0, 15));
            r_len  = r_on ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 40));
            for (int c = 0; c < r_len; c++) begin
                if ($urandom_range(0, 7) == 0) r_code = 4'($urandom_range(0, 15));
                tick(r_on, r_code);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
